// File: rtl/clk_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding and default timing constants.
package clk_pkg;

    typedef enum logic [1:0] {
        S_PRST   = 2'b00,
        S_WAIT   = 2'b01,
        S_STABLE = 2'b10,
        S_RUN    = 2'b11
    } pll_state_e;

    localparam int PLL_RST_CYCLES_DEF = 16;
    localparam int LOCK_STABLE_DEF    = 1024;
    localparam int LOCK_TIMEOUT_DEF   = 65536;
    localparam int LOST_FILTER_DEF    = 4;
    localparam int RELOCK_W           = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pll_reset_ctl_sync2.sv
// Generic two-flop synchroniser with synchronous active-low clear.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/pll_reset_ctl.sv
// PLL reset sequencer: pulses PLL reset, qualifies lock, releases system reset,
// and re-arms the PLL on lock loss, lock timeout or explicit request.
//
// state    | meaning
// S_PRST   | PLL reset asserted for PLL_RST_CYCLES
// S_WAIT   | waiting for synchronised lock, bounded by LOCK_TIMEOUT
// S_STABLE | counting consecutive locked cycles up to LOCK_STABLE
// S_RUN    | system reset released; filtering for LOST_FILTER unlocked cycles
module pll_reset_ctl
    import clk_pkg::*;
#(
    parameter int PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
    parameter int LOCK_STABLE    = LOCK_STABLE_DEF,
    parameter int LOCK_TIMEOUT   = LOCK_TIMEOUT_DEF,
    parameter int LOST_FILTER    = LOST_FILTER_DEF
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                locked_in,
    input  logic                relock_req,
    output logic                pll_rst,
    output logic                sys_reset_n,
    output logic                ready,
    output logic [RELOCK_W-1:0] relock_count,
    output logic [1:0]          state_dbg
);

    localparam int CNT_W = $clog2(max4(PLL_RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT, LOST_FILTER)) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOST_LAST    = CNT_W'(LOST_FILTER - 1);

    pll_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RELOCK_W-1:0] relock_q, relock_d;
    logic                pll_rst_q, sys_reset_n_q, ready_q;
    logic                bump;
    logic                lk;

    sync2 #(.W(1)) u_lock_sync (
        .clk_i   (clock),
        .rst_n_i (reset_n),
        .d_i     (locked_in),
        .q_o     (lk)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        relock_d = relock_q;
        bump     = 1'b0;

        if (relock_req) begin
            state_d = S_PRST;
            bump    = 1'b1;
        end else begin
            case (state_q)
                S_PRST: begin
                    if (cnt_q == RST_LAST) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (lk) begin
                        state_d = S_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = S_PRST;
                        bump    = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lk) state_d = S_WAIT;
                    else if (cnt_q == STABLE_LAST) state_d = S_RUN;
                end
                S_RUN: begin
                    if (lk) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOST_LAST) begin
                        state_d = S_PRST;
                        bump    = 1'b1;
                    end
                end
                default: state_d = S_PRST;
            endcase
        end

        // A request in S_PRST keeps the state but must still restart the hold.
        if ((state_d != state_q) || relock_req) cnt_d = '0;

        if (bump && (relock_q != '1)) relock_d = relock_q + RELOCK_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= S_PRST;
            cnt_q         <= '0;
            relock_q      <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            relock_q      <= relock_d;
            pll_rst_q     <= (state_d == S_PRST);
            sys_reset_n_q <= (state_d == S_RUN);
            ready_q       <= (state_d == S_RUN);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_reset_n  = sys_reset_n_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;
    assign state_dbg    = state_q;

endmodule
